// File: rtl/cart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cart_pkg
//  Purpose  : Shared types and constants for the cartridge memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package cart_pkg;

  // Memory ownership phases: boot idle, loader writing, mask latch, CPU run.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MASK = 2'd2,
    RUN  = 2'd3
  } cart_state_t;

  // ioctl_index value that selects a cartridge download.
  localparam logic [7:0] CART_INDEX_DEF = 8'd1;

  // Value returned for reads that cannot reach the memory.
  localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/cart_mask_calc.sv
`default_nettype none
// ============================================================================
//  Module   : cart_mask_calc
//  Purpose  : Combinational address mask = (smallest power of two >= size)-1.
//             A size of zero, or a full-size image, yields all ones.
//  Revision : 1.0 - initial release
// ============================================================================
module cart_mask_calc #(
  parameter int ADDR_W = 14
) (
  input  logic [ADDR_W:0]   size,
  output logic [ADDR_W-1:0] mask
);

  // Highest addressed byte; wraps to all ones for size 0 and for 2^ADDR_W.
  logic [ADDR_W-1:0] last;
  assign last = size[ADDR_W-1:0] - ADDR_W'(1);

  // Smear the leading one of (size-1) down to bit 0.
  generate
    for (genvar i = 0; i < ADDR_W; i++) begin : g_smear
      assign mask[i] = size[ADDR_W] | (|last[ADDR_W-1:i]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cart_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cart_mem_arb
//  Purpose  : Arbitrates a single-port cartridge RAM between the hps_io
//             download stream and the CPU read port, tracks image size,
//             overflow and (optionally) a byte checksum.
//  Options  : CART_CHECKSUM_EN - when defined, cart_sum is the mod-2^16 sum of
//             every byte written during a load; otherwise cart_sum is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module cart_mem_arb
  import cart_pkg::*;
#(
  parameter logic [7:0] CART_INDEX = CART_INDEX_DEF,
  parameter int         ADDR_W     = 14
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W:0]   cart_size,
  output logic              cart_loaded,
  output logic              cart_ovf,
  output logic [15:0]       cart_sum
);

  cart_state_t       state, state_nxt;
  logic              dl_match, in_range, accept, ovf_hit, enter_load;
  logic              wr_pend;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] mask, mask_calc;
  logic              rd_mem;

  assign dl_match   = ioctl_download && (ioctl_index == CART_INDEX);
  assign in_range   = (ioctl_addr[24:ADDR_W] == '0);
  assign accept     = (state == LOAD) && ioctl_wr && in_range;
  assign ovf_hit    = (state == LOAD) && ioctl_wr && !in_range;
  assign enter_load = (state_nxt == LOAD) && (state != LOAD);

  cart_mask_calc #(.ADDR_W(ADDR_W)) u_mask (
    .size (cart_size),
    .mask (mask_calc)
  );

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and memory-port steering; writes own the port outside RUN.
  always_comb begin
    state_nxt = state;
    cpu_hold  = 1'b1;
    mem_addr  = wr_addr;
    case (state)
      IDLE: if (dl_match) state_nxt = LOAD;
      LOAD: if (!ioctl_download) state_nxt = MASK;
      MASK: state_nxt = RUN;
      RUN: begin
        cpu_hold = 1'b0;
        mem_addr = cpu_addr & mask;
        if (dl_match) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accepted download bytes are registered and written one cycle later.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_pend <= accept;
      if (accept) begin
        wr_addr <= ioctl_addr[ADDR_W-1:0];
        wr_data <= ioctl_dout;
      end
    end
  end

  assign mem_we    = wr_pend;
  assign mem_wdata = wr_data;

  // Image bookkeeping: cleared on each new load, mask latched in MASK.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cart_size   <= '0;
      cart_ovf    <= 1'b0;
      cart_loaded <= 1'b0;
      mask        <= '1;
    end else if (enter_load) begin
      cart_size   <= '0;
      cart_ovf    <= 1'b0;
      cart_loaded <= 1'b0;
    end else begin
      if (accept && ({1'b0, ioctl_addr[ADDR_W-1:0]} >= cart_size))
        cart_size <= {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
      if (ovf_hit) cart_ovf <= 1'b1;
      if (state == MASK) begin
        mask <= mask_calc;
        if (cart_size != '0) cart_loaded <= 1'b1;
      end
    end
  end

`ifdef CART_CHECKSUM_EN
  logic [15:0] sum;

  // Running checksum of the bytes actually written to memory.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        sum <= '0;
    else if (enter_load) sum <= '0;
    else if (accept)     sum <= sum + {8'h00, ioctl_dout};
  end

  assign cart_sum = sum;
`else
  assign cart_sum = 16'h0000;
`endif

  // Read response pipeline: memory data in RUN, open bus otherwise.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rvalid <= 1'b0;
      rd_mem     <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_rd;
      rd_mem     <= cpu_rd && (state == RUN);
    end
  end

  assign cpu_rdata = !cpu_rvalid ? 8'h00 : (rd_mem ? mem_rdata : OPEN_BUS);

endmodule
`default_nettype wire

// File: doc/cart_mem_arb.md
CART_MEM_ARB -- requirements
Module: cart_mem_arb

Interface
REQ-001 Parameter CART_INDEX, default 8'd1, ioctl_index value that selects a cartridge download.
REQ-002 Parameter ADDR_W, default 14, cartridge memory address width (16 KB).
REQ-003 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  download window from hps_io.
REQ-006 ioctl_index  in  8  download target index.
REQ-007 ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 ioctl_addr  in  25  byte address of the strobed byte.
REQ-009 ioctl_dout  in  8  strobed byte.
REQ-010 cpu_addr  in  ADDR_W  CPU cartridge read address.
REQ-011 cpu_rd  in  1  CPU read request, one cycle.
REQ-012 cpu_rdata  out  8  read data.
REQ-013 cpu_rvalid  out  1  cpu_rdata valid, one cycle.
REQ-014 cpu_hold  out  1  keeps the CPU in reset while the memory is owned by the loader.
REQ-015 mem_addr  out  ADDR_W  single-port synchronous RAM address.
REQ-016 mem_we  out  1  RAM write enable.
REQ-017 mem_wdata  out  8  RAM write data.
REQ-018 mem_rdata  in  8  RAM read data, valid one cycle after the address.
REQ-019 cart_size  out  ADDR_W+1  loaded byte count, saturating at 2^ADDR_W.
REQ-020 cart_loaded  out  1  a cartridge has been loaded since reset.
REQ-021 cart_ovf  out  1  a byte was addressed at or beyond 2^ADDR_W.
REQ-022 cart_sum  out  16  byte checksum (see Configuration).

Function
REQ-023 The FSM SHALL have the states IDLE, LOAD, MASK and RUN.
- IDLE -> LOAD when ioctl_download=1 and ioctl_index=CART_INDEX.
- LOAD -> MASK on the falling edge of ioctl_download.
- MASK -> RUN after exactly one cycle.
- RUN -> LOAD on a new matching download.
REQ-024 A download with a non-matching index SHALL be ignored in every state.
REQ-025 On entry to LOAD, the block SHALL clear cart_size, cart_ovf, cart_sum and cart_loaded.
REQ-026 cpu_hold SHALL be 1 in IDLE, LOAD and MASK, and 0 only in RUN.
REQ-027 In LOAD, an ioctl_wr with ioctl_addr < 2^ADDR_W SHALL be registered and then drive mem_we=1 on the following cycle, with mem_addr=ioctl_addr[ADDR_W-1:0] and mem_wdata=ioctl_dout; this is a fixed write latency of 1.
REQ-028 In LOAD, an ioctl_wr with ioctl_addr >= 2^ADDR_W SHALL set cart_ovf, SHALL NOT write the memory, and SHALL leave cart_size unchanged.
REQ-029 cart_size SHALL hold max(ioctl_addr)+1 over all accepted writes.
REQ-030 In MASK, the block SHALL compute mask = (smallest power of two >= cart_size) - 1 and set cart_loaded=1 when cart_size != 0.
REQ-031 For cart_size=0, mask SHALL be all ones.
REQ-032 In RUN, cpu_rd SHALL drive mem_addr=cpu_addr & mask on the same cycle; cpu_rvalid=1 and cpu_rdata=mem_rdata SHALL follow exactly 1 cycle later, and reads are fully pipelined.
REQ-033 A cpu_rd outside RUN SHALL return cpu_rvalid=1 with cpu_rdata=8'hFF after 1 cycle, without any memory access.
REQ-034 mem_we SHALL be 0 outside LOAD, except for the single registered write that completes on the LOAD->MASK cycle.
REQ-035 When ioctl_wr coincides with the falling edge of ioctl_download, the block SHALL accept the byte before leaving LOAD.
REQ-036 A matching download starting while a CPU read is in flight SHALL still deliver that read's cpu_rvalid.

Reset
REQ-037 reset_n=0 SHALL asynchronously force IDLE, with:
- cpu_hold=1;
- all other outputs at 0;
- mask all ones;
- the write register cleared.
REQ-038 Reset during LOAD SHALL abort the load; the memory contents are then undefined and cart_loaded=0.

Configuration
REQ-039 With CART_CHECKSUM_EN defined, cart_sum SHALL be the modulo-2^16 sum of every byte written in LOAD.
REQ-040 With CART_CHECKSUM_EN undefined, cart_sum SHALL be constant 0 and no adder SHALL be present.

Structure
REQ-041 A shared package cart_pkg SHALL hold:
- the FSM state enum;
- the CART_INDEX default;
- the 8'hFF open-bus constant.
REQ-042 The power-of-two mask computation SHALL live in the sub-module cart_mask_calc, which is purely combinational and registered in MASK.

Verification
REQ-043 Download index 1 of 3000 bytes -> after the falling edge, cart_size=3000, mask=0x0FFF, cart_loaded=1 and cpu_hold=0 two cycles later.
REQ-044 In RUN with 3000 bytes loaded, cpu_rd at cpu_addr=0x1005 -> mem_addr=0x0005 and cpu_rvalid one cycle later with the byte at address 5.
REQ-045 Download index 2 -> no mem_we, state unchanged, cart_size unchanged.
REQ-046 Byte at ioctl_addr=0x4000 -> cart_ovf=1, no write, cart_size unchanged.
REQ-047 reset_n pulsed low mid-LOAD -> IDLE immediately, cpu_hold=1, cart_loaded=0; a cpu_rd then returns 8'hFF.
REQ-048 Bytes 0x01, 0xFF, 0x10 with CART_CHECKSUM_EN defined -> cart_sum=0x0110; without the macro -> cart_sum=0.
